// File: rtl/prefix_subtractor_pipe_pkg.sv
// Shared definitions for the prefix subtractor pipeline: default sizes, the
// generate/propagate pair type, the prefix combine operator and the size check.
package prefix_subtractor_pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LOG2W = 5;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Upper span absorbs the lower span: G = Gh | Ph&Gl, P = Ph&Pl.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic bit width_ok(input int width, input int log2w);
    return (width >= 4) && (log2w > 0) && (log2w < 31) && (width == (1 << log2w));
  endfunction

endpackage

// File: rtl/prefix_subtractor_pipe_level.sv
// One Kogge-Stone combine level (module prefix_level): bit i absorbs bit i-DIST,
// then the level is registered. The side-band bus rides along unchanged.
module prefix_level
  import prefix_subtractor_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIST  = 1,
  parameter int SBW   = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_p,
  input  logic [SBW-1:0]   i_sb,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_g,
  output logic [WIDTH-1:0] o_p,
  output logic [SBW-1:0]   o_sb
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  gp_t              w_c;

  logic             r_valid;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_p;
  logic [SBW-1:0]   r_sb;

  // Bits below DIST already span down to bit 0 and pass straight through.
  always_comb begin
    w_g = i_g;
    w_p = i_p;
    w_c = '0;
    for (int i = DIST; i < WIDTH; i++) begin
      w_c    = gp_combine(gp_t'({i_g[i], i_p[i]}), gp_t'({i_g[i-DIST], i_p[i-DIST]}));
      w_g[i] = w_c.g;
      w_p[i] = w_c.p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_g     <= '0;
      r_p     <= '0;
      r_sb    <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_g     <= w_g;
      r_p     <= w_p;
      r_sb    <= i_sb;
    end
  end

  assign o_valid = r_valid;
  assign o_g     = r_g;
  assign o_p     = r_p;
  assign o_sb    = r_sb;

endmodule

// File: rtl/prefix_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor (a + ~b + 1) with valid/ready on both sides.
// Define SUB_FLAGS_EN to add out_zero/out_ovf and the sign-bit pipeline.
module prefix_subtractor_pipe
  import prefix_subtractor_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LOG2W = DEF_LOG2W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow
`ifdef SUB_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_ovf
`endif
);

`ifdef SUB_FLAGS_EN
  localparam int SBW = WIDTH + 2;
`else
  localparam int SBW = WIDTH;
`endif

  if (!width_ok(WIDTH, LOG2W)) begin : g_bad_width
    $error("prefix_subtractor_pipe: WIDTH must equal 2**LOG2W and be >= 4");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_g0;
  logic [WIDTH-1:0] w_p0;
  logic [SBW-1:0]   w_sb0;

  logic             r_v0;
  logic [WIDTH-1:0] r_g0;
  logic [SBW-1:0]   r_sb0;

  logic             w_v  [0:LOG2W];
  logic [WIDTH-1:0] w_g  [0:LOG2W];
  logic [WIDTH-1:0] w_p  [0:LOG2W];
  logic [SBW-1:0]   w_sb [0:LOG2W];

  logic [WIDTH-1:0] w_praw;
  logic [WIDTH-1:0] w_gf;
  logic [WIDTH-1:0] w_diff;

  assign w_adv    = !w_v[LOG2W] || out_ready;
  assign in_ready = w_adv;

  // The +1 of two's-complement subtraction enters as a carry-in at bit 0.
  always_comb begin
    w_p0    = a ^ ~b;
    w_g0    = a & ~b;
    w_g0[0] = w_g0[0] | w_p0[0];
  end

  // Side-band carries the raw bit propagates (needed for the sum) and, with flags, the MSBs.
`ifdef SUB_FLAGS_EN
  assign w_sb0 = {a[WIDTH-1], b[WIDTH-1], w_p0};
`else
  assign w_sb0 = w_p0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0  <= 1'b0;
      r_g0  <= '0;
      r_sb0 <= '0;
    end else if (w_adv) begin
      r_v0  <= in_valid;
      r_g0  <= w_g0;
      r_sb0 <= w_sb0;
    end
  end

  assign w_v[0]  = r_v0;
  assign w_g[0]  = r_g0;
  assign w_p[0]  = r_sb0[WIDTH-1:0];
  assign w_sb[0] = r_sb0;

  for (genvar k = 1; k <= LOG2W; k++) begin : g_level
    prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << (k - 1)),
      .SBW   (SBW)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_valid (w_v[k-1]),
      .i_g     (w_g[k-1]),
      .i_p     (w_p[k-1]),
      .i_sb    (w_sb[k-1]),
      .o_valid (w_v[k]),
      .o_g     (w_g[k]),
      .o_p     (w_p[k]),
      .o_sb    (w_sb[k])
    );
  end

  assign w_praw = w_sb[LOG2W][WIDTH-1:0];
  assign w_gf   = w_g[LOG2W];
  assign w_diff = w_praw ^ {w_gf[WIDTH-2:0], 1'b1};

  // Gated by valid so an empty output stage reads as all zeros.
  assign out_valid  = w_v[LOG2W];
  assign out_diff   = out_valid ? w_diff : '0;
  assign out_borrow = out_valid & ~w_gf[WIDTH-1];

`ifdef SUB_FLAGS_EN
  assign out_zero = out_valid & (w_diff == '0);
  assign out_ovf  = out_valid & (w_sb[LOG2W][WIDTH+1] ^ w_sb[LOG2W][WIDTH])
                              & (w_sb[LOG2W][WIDTH+1] ^ w_diff[WIDTH-1]);
`endif

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Bench for prefix_subtractor_pipe at WIDTH=32: arithmetic reference model with an
// ordered expectation queue, plus directed literal vectors, stalls and mid-flight reset.
module tb_prefix_subtractor_pipe;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a         = '0;
  logic [31:0] b         = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_borrow;
  logic [31:0] out_diff;
`ifdef SUB_FLAGS_EN
  logic        out_zero;
  logic        out_ovf;
`endif

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] d;
    logic        bo;
`ifdef SUB_FLAGS_EN
    logic        z;
    logic        ov;
`endif
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  prefix_subtractor_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_borrow (out_borrow)
`ifdef SUB_FLAGS_EN
    ,
    .out_zero   (out_zero),
    .out_ovf    (out_ovf)
`endif
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: widen to 33 bits and subtract; signed overflow from a sign-extended subtract.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [32:0] u;
`ifdef SUB_FLAGS_EN
    logic signed [32:0] s;
`endif
    u    = {1'b0, x} - {1'b0, y};
    e.d  = u[31:0];
    e.bo = u[32];
`ifdef SUB_FLAGS_EN
    s    = $signed({x[31], x}) - $signed({y[31], y});
    e.z  = (u[31:0] == 32'd0);
    e.ov = (s[32] != s[31]);
`endif
    return e;
  endfunction

  // Single compare process: handshakes are judged at the negedge, mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_diff", out_diff, 0);
      check("rst_out_borrow", out_borrow, 0);
      check("rst_in_ready", in_ready, 1);
`ifdef SUB_FLAGS_EN
      check("rst_out_zero", out_zero, 0);
      check("rst_out_ovf", out_ovf, 0);
`endif
    end else begin
      check("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", out_valid, 0);
        end else begin
          check("out_diff", out_diff, exp_q[0].d);
          check("out_borrow", out_borrow, exp_q[0].bo);
`ifdef SUB_FLAGS_EN
          check("out_zero", out_zero, exp_q[0].z);
          check("out_ovf", out_ovf, exp_q[0].ov);
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one op into an empty pipe; returns #1 after the edge where the result appears.
  task automatic single_op(input string nm, input logic [31:0] a_i, input logic [31:0] b_i,
                           input logic [31:0] exp_d, input logic exp_bo);
    int cyc;
    @(posedge clk);
    #1;
    a        = a_i;
    b        = b_i;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc      = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({nm, "_latency"}, cyc, 6);
    check({nm, "_diff"}, out_diff, exp_d);
    check({nm, "_borrow"}, out_borrow, exp_bo);
  endtask

  logic [31:0] sa [8] = '{32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'h80000000,
                          32'h00000001, 32'h12345678, 32'hFFFF0000, 32'h00010000};
  logic [31:0] sb [8] = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                          32'h00000002, 32'h12345679, 32'h0000FFFF, 32'h00000001};

  initial begin
    int t;
    int run;
    int seen;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_diff", out_diff, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    idle(2);

    single_op("t1", 32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAB, 1'b1);
    single_op("t2a", 32'hAAAAAAAA, 32'h55555555, 32'h55555555, 1'b0);
    single_op("t2b", 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1);
    single_op("t6a", 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0);
`ifdef SUB_FLAGS_EN
    check("t6a_ovf", out_ovf, 1);
    check("t6a_zero", out_zero, 0);
`endif
    single_op("t6b", 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b0);
`ifdef SUB_FLAGS_EN
    check("t6b_zero", out_zero, 1);
    check("t6b_ovf", out_ovf, 0);
`endif
    idle(2);

    // Back-to-back stream: results must come out on consecutive cycles.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a        = sa[i];
          b        = sb[i];
          in_valid = 1'b1;
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        t = 0;
        while (t < 60) begin
          @(negedge clk);
          t++;
          if (out_valid) break;
        end
        run = 0;
        while (out_valid && run < 20) begin
          run++;
          @(negedge clk);
        end
        check("stream_run_length", run, 8);
      end
    join
    idle(3);
    check("stream_queue_empty", exp_q.size(), 0);

    // Stall with a result waiting while the producer holds a new op.
    out_ready = 1'b0;
    single_op("stall_a", 32'h00000010, 32'h00000001, 32'h0000000F, 1'b0);
    a        = 32'h00000100;
    b        = 32'h00000200;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_diff_stable", out_diff, 32'h0000000F);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stall_b_diff", out_diff, 32'hFFFFFF00);
    check("stall_b_borrow", out_borrow, 1);
    idle(3);
    check("stall_queue_empty", exp_q.size(), 0);

    // Reset with three ops in flight, the oldest waiting at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a        = 32'h00001000 + 32'(i);
      b        = 32'h00000003;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_diff", out_diff, 0);
    check("midrst_out_borrow", out_borrow, 0);
    check("midrst_in_ready", in_ready, 1);
    idle(2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("post_reset_emits", seen, 0);

    single_op("recover", 32'h00000005, 32'h00000003, 32'h00000002, 1'b0);
    idle(3);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "bench timeout");
  end

endmodule
